serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
//  Downstream consumer of the single-bit registered D-flop stage. Frames the
//  bit stream into WIDTH-bit words: start bit, WIDTH data bits LSB-first,
//  parity bit, stop bit. Presents each word on a valid/ready output port.
//  Flags parity, framing and overrun errors.
// PARAMETERS
//  WIDTH        8   data bits per frame (>=2)
//  EVEN_PARITY  1   1: expected parity = ^data; 0: expected parity = ~^data
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  bit_in      in   1      serial bit (registered Q of upstream flop)
//  bit_en      in   1      bit_in is sampled only on edges where bit_en=1
//  data_out    out  WIDTH  collected word, stable while data_valid=1
//  data_valid  out  1      word available
//  data_ready  in   1      consumer accepts on data_valid & data_ready edge
//  parity_err  out  1      parity mismatch for the word on data_out
//  frame_err   out  1      one-cycle pulse: stop bit was 1, frame dropped
//  overrun     out  1      sticky: good frame dropped, output still held
// BEHAVIOUR
//  Reset (async, immediate, any state incl. mid-frame):
//   - FSM -> IDLE; bit counter = 0; shift register = 0
//   - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0
//  FSM (advances only on edges with bit_en=1; else holds all state):
//   - IDLE:   bit_in=1 -> DATA, count=0. bit_in=0 -> stay (idle line).
//   - DATA:   shift[count] <= bit_in; count++. After WIDTH-th bit -> PARITY.
//   - PARITY: capture bit; err = (bit != expected parity of shift) -> STOP.
//   - STOP:   bit_in=0 -> frame good -> IDLE (load attempt below).
//             bit_in=1 -> frame_err=1 for exactly one cycle; word dropped;
//             -> IDLE. This bit is NOT reused as a start bit.
//  Output register:
//   - Load on the STOP edge of a good frame when data_valid=0, or when
//     data_valid=1 & data_ready=1 on the same edge (accept+load). Load sets
//     data_out=shift, parity_err=err, data_valid=1.
//   - Visible the cycle after the edge that samples the stop bit
//     (latency: 1 clock after stop-bit sample).
//   - Good frame while data_valid=1 & data_ready=0: word dropped; overrun=1.
//     data_out and parity_err unchanged. overrun clears only on reset.
//   - data_valid & data_ready with no load on that edge: data_valid -> 0
//     on that edge. data_out retains the last word.
//   - parity_err is qualified by data_valid and changes only on load.
//  Parity errors do not drop the word. It is delivered with parity_err=1.
//  frame_err pulses independent of output-register occupancy.
//  bit_en=0 for any number of cycles mid-frame: no timeout, frame resumes.
// TESTING
//  1 Async reset mid-DATA (after 3 data bits): assert reset between edges
//    -> all outputs 0 immediately. Next frame 0x5A decodes correctly.
//  2 Good frame, WIDTH=8, EVEN: start 1, data 0xA5 (1,0,1,0,0,1,0,1),
//    parity 0, stop 0, data_ready=1 -> data_out=0xA5, data_valid=1
//    one cycle after stop edge, parity_err=0. Valid drops next edge.
//  3 Same frame with parity 1 -> data_out=0xA5, parity_err=1, frame_err=0.
//  4 Frame 0x0F with stop 1 -> frame_err high exactly 1 cycle,
//    data_valid stays 0. Next frame 0x81 decodes correctly.
//  5 Backpressure: data_ready=0, frames 0x3C then 0x81 -> data_out=0x3C,
//    overrun=1. Raise data_ready -> valid falls, data_out stays 0x3C.
//  6 bit_en=1 every 3rd cycle only, 5 idle zeros, then frame 0xC3 ->
//    data_out=0xC3 and parity_err=0 (same as continuous bit_en).
//    Bits with bit_en=0 never alter state.

Source files
------------

// File: rtl/serial_word_collector.sv
// Frames a gated serial bit stream (start, WIDTH data bits LSB-first, parity, stop)
// into words presented on a valid/ready port, flagging parity, framing and overrun errors.
module serial_word_collector #(
    parameter int WIDTH       = 8,
    parameter bit EVEN_PARITY = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    function automatic logic expected_parity(input logic [WIDTH-1:0] word);
        if (EVEN_PARITY) begin
            return ^word;
        end else begin
            return ~^word;
        end
    endfunction

    // Next-state for the framer and the output holding register.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        err_d   = err_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;
        // The consumer handshake runs every cycle, independent of bit_en.
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (bit_in) begin
                        state_d = S_DATA;
                        count_d = CNT_ZERO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    shift_d[count_q] = bit_in;
                    if (count_q == CNT_LAST) begin
                        state_d = S_PARITY;
                        count_d = CNT_ZERO;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    err_d   = (bit_in != expected_parity(shift_q));
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (bit_in) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || data_ready) begin
                        dout_d  = shift_q;
                        perr_d  = err_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= CNT_ZERO;
            shift_q <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed and randomized frames for serial_word_collector, checked against a
// transaction-level model of the output port.
module tb_serial_word_collector;

    localparam int W    = 8;
    localparam bit EVEN = 1'b1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         bit_in = 1'b0;
    logic         bit_en = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready = 1'b0;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_data;
    logic         exp_valid, exp_perr, exp_ferr, exp_ovr;

    serial_word_collector #(.WIDTH(W), .EVEN_PARITY(EVEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, 32'(data_valid), 32'(exp_valid));
        check({tag, "_data"},  32'(data_out),   32'(exp_data));
        check({tag, "_perr"},  32'(parity_err), 32'(exp_perr));
        check({tag, "_ferr"},  32'(frame_err),  32'(exp_ferr));
        check({tag, "_ovr"},   32'(overrun),    32'(exp_ovr));
    endtask

    task automatic model_clear();
        exp_data = '0; exp_valid = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic step(input logic b, input logic en);
        bit_in = b;
        bit_en = en;
        @(posedge clock);
        #1;
    endtask

    // Any edge with no frame completing: a pending word is taken if ready.
    task automatic model_accept();
        if (data_ready && exp_valid) exp_valid = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit pflip, input bit stopbit,
                              input bit rdy, input int gap, input bit rgap, input string tag);
        logic [W+2:0] fr;
        logic         p;
        int           n;
        p  = EVEN ? logic'($countones(d) % 2) : logic'(1 - ($countones(d) % 2));
        p  = p ^ pflip;
        fr = {stopbit, p, d, 1'b1};
        data_ready = rdy;
        for (int k = 0; k < W + 3; k++) begin
            n = rgap ? int'($urandom_range(gap, 0)) : gap;
            repeat (n) begin
                step(1'($urandom), 1'b0);
                model_accept();
            end
            step(fr[k], 1'b1);
            if (k < W + 2) begin
                model_accept();
            end else if (stopbit) begin
                exp_ferr = 1'b1;
            end else if (!exp_valid || rdy) begin
                exp_data = d; exp_perr = pflip; exp_valid = 1'b1; exp_ferr = 1'b0;
            end else begin
                exp_ovr = 1'b1; exp_ferr = 1'b0;
            end
            if (k == 0) check({tag, "_valid_mid"}, 32'(data_valid), 32'(exp_valid));
        end
        check_all(tag);
        step(1'($urandom), 1'b0);
        model_accept();
        check({tag, "_ferr_after"},  32'(frame_err),  32'(exp_ferr));
        check({tag, "_valid_after"}, 32'(data_valid), 32'(exp_valid));
    endtask

    task automatic drain(input string tag);
        data_ready = 1'b1;
        step(1'b0, 1'b0);
        model_accept();
        check_all(tag);
    endtask

    initial begin
        model_clear();
        repeat (2) step(1'b0, 1'b0);
        check_all("reset");
        reset = 1'b0;
        step(1'b0, 1'b1);
        check_all("post_reset");

        // Good frame, then same word with bad parity held under backpressure.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, 1'b0, "good_a5");
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0, "perr_a5");

        // Asynchronous reset mid-DATA after three data bits.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_all("async_reset");
        #2 reset = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, 1'b0, "after_rst_5a");

        // Framing error then recovery.
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 0, 1'b0, "ferr_0f");
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b0, "after_ferr_81");
        drain("drain_81");

        // Backpressure overrun.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0, "bp_3c");
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b0, "bp_81");
        drain("bp_drain");

        // Enable every third cycle with an idle line first.
        repeat (5) begin
            step(1'($urandom), 1'b0);
            step(1'($urandom), 1'b0);
            step(1'b0, 1'b1);
            model_accept();
        end
        check_all("slow_idle");
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 2, 1'b0, "slow_c3");

        // Randomized traffic from a clean state.
        reset = 1'b1;
        #2 reset = 1'b0;
        model_clear();
        for (int i = 0; i < 40; i++) begin
            send_frame(W'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
                       1'($urandom_range(1, 0)), 2, 1'b1, "rand");
            if ($urandom_range(3, 0) == 0) begin
                step(1'b0, 1'b1);
                model_accept();
            end
        end
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
